// File: rtl/gray_ptr_sync_mc.sv
// Multi-channel gray pointer synchroniser: SYNC_STAGES-deep chain, registered binary, update strobe.
// Define GRAY_SYNC_CHK_EN to add sticky per-channel multi-bit-change detection on ptr_err_o.
module gray_ptr_sync_mc #(
   parameter int PTR_WIDTH   = 5,
   parameter int CH_NUM      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            dst_clk_i,
   input  logic                            rst_i,
   input  logic [CH_NUM*(PTR_WIDTH+1)-1:0] ptr_gray_i,
   input  logic [CH_NUM-1:0]               err_clr_i,
   output logic [CH_NUM*(PTR_WIDTH+1)-1:0] ptr_gray_o,
   output logic [CH_NUM*(PTR_WIDTH+1)-1:0] ptr_bin_o,
   output logic [CH_NUM-1:0]               ptr_upd_o,
   output logic [CH_NUM-1:0]               ptr_err_o
);
   localparam int PW = PTR_WIDTH + 1;
   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic [NS-1:0][PW-1:0] sync_d, sync_q;
      logic [PW-1:0]         gray_last;
      logic [PW-1:0]         prev_d, prev_q;
      logic [PW-1:0]         bin_d, bin_q;
      logic                  upd_d, upd_q;
      logic                  err_d, err_q;

      assign gray_last = sync_q[NS-1];

      always_comb begin
         // stage 0 takes the raw input; stage NS-1 is the synchronised pointer
         sync_d = {sync_q[NS-2:0], ptr_gray_i[c*PW +: PW]};
         prev_d = gray_last;
         bin_d  = '0;
         for (int i = 0; i < PW; i++) begin
            bin_d[i] = ^(gray_last >> i);
         end
         upd_d = (gray_last != prev_q);
`ifdef GRAY_SYNC_CHK_EN
         err_d = err_q;
         if (err_clr_i[c]) begin
            err_d = 1'b0;
         end
         if ($countones(gray_last ^ prev_q) > 1) begin
            err_d = 1'b1;
         end
`else
         err_d = 1'b0;
`endif
      end

      always_ff @(posedge dst_clk_i or posedge rst_i) begin
         if (rst_i) begin
            sync_q <= '0;
            prev_q <= '0;
            bin_q  <= '0;
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
         end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            bin_q  <= bin_d;
            upd_q  <= upd_d;
            err_q  <= err_d;
         end
      end

      assign ptr_gray_o[c*PW +: PW] = gray_last;
      assign ptr_bin_o[c*PW +: PW]  = bin_q;
      assign ptr_upd_o[c]           = upd_q;
      assign ptr_err_o[c]           = err_q;
   end

`ifndef GRAY_SYNC_CHK_EN
   logic unused_err_clr;
   assign unused_err_clr = ^err_clr_i;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_mc.sv
// Directed bench for gray_ptr_sync_mc: 4-channel/2-stage instance plus a 1-channel/3-stage instance.
module tb_gray_ptr_sync_mc;
   localparam int PW = 6;
   localparam int CH = 4;
`ifdef GRAY_SYNC_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [CH*PW-1:0] gray_i;
   logic [CH-1:0]    clr_i;
   logic [CH*PW-1:0] gray_o, bin_o;
   logic [CH-1:0]    upd_o, err_o;

   logic [PW-1:0]    g3_i;
   logic             clr3_i;
   logic [PW-1:0]    g3_o, b3_o;
   logic             u3_o, e3_o;

   int checks = 0;
   int errors = 0;

   gray_ptr_sync_mc #(.PTR_WIDTH(5), .CH_NUM(4), .SYNC_STAGES(2)) dut (
      .dst_clk_i(clk), .rst_i(rst), .ptr_gray_i(gray_i), .err_clr_i(clr_i),
      .ptr_gray_o(gray_o), .ptr_bin_o(bin_o), .ptr_upd_o(upd_o), .ptr_err_o(err_o)
   );

   gray_ptr_sync_mc #(.PTR_WIDTH(5), .CH_NUM(1), .SYNC_STAGES(3)) dut3 (
      .dst_clk_i(clk), .rst_i(rst), .ptr_gray_i(g3_i), .err_clr_i(clr3_i),
      .ptr_gray_o(g3_o), .ptr_bin_o(b3_o), .ptr_upd_o(u3_o), .ptr_err_o(e3_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; gray_i = '0; clr_i = '0; g3_i = '0; clr3_i = 1'b0;
      tick(2);
      checks++; if (gray_o !== '0) begin errors++; $display("FAIL reset_gray: got %h expected 0", gray_o); end
      checks++; if (bin_o !== '0) begin errors++; $display("FAIL reset_bin: got %h expected 0", bin_o); end
      rst = 1'b0;
      gray_i = {CH*PW{1'b1}};
      tick(5);
      // async assertion: outputs must clear before any further clock edge
      rst = 1'b1;
      #1;
      checks++; if ({gray_o, bin_o, upd_o, err_o} !== '0) begin errors++; $display("FAIL reset_async: got %h/%h/%h/%h expected all 0", gray_o, bin_o, upd_o, err_o); end
      tick(1);
      rst = 1'b0;
      tick(1);
      checks++; if ({gray_o, upd_o} !== '0) begin errors++; $display("FAIL reset_rel_e1: got gray %h upd %h expected 0", gray_o, upd_o); end
      tick(1);
      checks++; if (gray_o !== 24'hFFFFFF || upd_o !== 4'h0) begin errors++; $display("FAIL reset_rel_e2: got gray %h upd %h expected ffffff/0", gray_o, upd_o); end
      tick(1);
      checks++; if (upd_o !== 4'hF || bin_o !== 24'hAAAAAA) begin errors++; $display("FAIL reset_rel_e3: got upd %h bin %h expected f/aaaaaa", upd_o, bin_o); end
      checks++; if (err_o !== {CH{CHK}}) begin errors++; $display("FAIL reset_rel_err: got %h expected %h", err_o, {CH{CHK}}); end
      tick(1);
      checks++; if (upd_o !== 4'h0) begin errors++; $display("FAIL reset_rel_e4: got upd %h expected 0", upd_o); end
      gray_i = '0;
      do_reset();
   endtask

   task automatic test_latency();
      gray_i[5:0] = 6'b000110;
      tick(5);
      checks++; if (bin_o[5:0] !== 6'd4 || upd_o !== 4'h0) begin errors++; $display("FAIL lat_pre: got bin %h upd %h expected 04/0", bin_o[5:0], upd_o); end
      gray_i[5:0] = 6'b000111;
      tick(1);
      checks++; if (gray_o[5:0] !== 6'b000110) begin errors++; $display("FAIL lat_e1: got gray %b expected 000110", gray_o[5:0]); end
      tick(1);
      checks++; if (gray_o[5:0] !== 6'b000111 || bin_o[5:0] !== 6'd4 || upd_o !== 4'h0) begin errors++; $display("FAIL lat_e2: got gray %b bin %0d upd %h expected 000111/4/0", gray_o[5:0], bin_o[5:0], upd_o); end
      tick(1);
      checks++; if (bin_o[5:0] !== 6'b000101 || upd_o !== 4'b0001) begin errors++; $display("FAIL lat_e3: got bin %b upd %b expected 000101/0001", bin_o[5:0], upd_o); end
      tick(1);
      checks++; if (upd_o !== 4'h0) begin errors++; $display("FAIL lat_e4: got upd %b expected 0000", upd_o); end
   endtask

   task automatic test_wrap();
      logic [PW-1:0] seq [2];
      logic [PW-1:0] exp_bin [2];
      seq[0] = 6'b100000; exp_bin[0] = 6'd63;
      seq[1] = 6'b000000; exp_bin[1] = 6'd0;
      gray_i[5:0] = 6'b100001;
      tick(5);
      clr_i = 4'hF;
      tick(1);
      clr_i = 4'h0;
      checks++; if (bin_o[5:0] !== 6'd62 || err_o !== 4'h0) begin errors++; $display("FAIL wrap_pre: got bin %0d err %b expected 62/0", bin_o[5:0], err_o); end
      for (int s = 0; s < 2; s++) begin
         gray_i[5:0] = seq[s];
         for (int k = 1; k <= 4; k++) begin
            tick(1);
            checks++; if (upd_o[0] !== (k == 3)) begin errors++; $display("FAIL wrap_upd s%0d e%0d: got %b expected %b", s, k, upd_o[0], (k == 3)); end
         end
         checks++; if (bin_o[5:0] !== exp_bin[s] || err_o !== 4'h0) begin errors++; $display("FAIL wrap_bin s%0d: got bin %0d err %b expected %0d/0", s, bin_o[5:0], err_o, exp_bin[s]); end
      end
   endtask

   task automatic test_back_to_back();
      gray_i[5:0] = 6'b000001;
      tick(1);
      gray_i[5:0] = 6'b000011;
      tick(1);
      gray_i[5:0] = 6'b000010;
      tick(1);
      checks++; if (bin_o[5:0] !== 6'd1 || upd_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_1: got bin %0d upd %b expected 1/1", bin_o[5:0], upd_o[0]); end
      tick(1);
      checks++; if (bin_o[5:0] !== 6'd2 || upd_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_2: got bin %0d upd %b expected 2/1", bin_o[5:0], upd_o[0]); end
      tick(1);
      checks++; if (bin_o[5:0] !== 6'd3 || upd_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_3: got bin %0d upd %b expected 3/1", bin_o[5:0], upd_o[0]); end
      tick(1);
      checks++; if (upd_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_end: got upd %b expected 0", upd_o[0]); end
      gray_i[5:0] = 6'b000000;
      tick(4);
   endtask

   task automatic test_error();
      gray_i[5:0] = 6'b000011;
      tick(3);
      checks++; if (err_o !== {3'b000, CHK} || bin_o[5:0] !== 6'd2) begin errors++; $display("FAIL err_set: got err %b bin %0d expected %b/2", err_o, bin_o[5:0], {3'b000, CHK}); end
      tick(2);
      checks++; if (err_o !== {3'b000, CHK}) begin errors++; $display("FAIL err_hold: got %b expected %b", err_o, {3'b000, CHK}); end
      clr_i[0] = 1'b1;
      tick(1);
      clr_i[0] = 1'b0;
      checks++; if (err_o !== 4'h0) begin errors++; $display("FAIL err_clr: got %b expected 0000", err_o); end
      // second two-bit jump with clear asserted in the very cycle the error is raised
      gray_i[5:0] = 6'b000000;
      tick(2);
      clr_i[0] = 1'b1;
      tick(1);
      clr_i[0] = 1'b0;
      checks++; if (err_o !== {3'b000, CHK}) begin errors++; $display("FAIL err_set_wins: got %b expected %b", err_o, {3'b000, CHK}); end
      do_reset();
   endtask

   task automatic test_multi_channel();
      gray_i = '0;
      gray_i[5:0]   = 6'b000001;
      gray_i[23:18] = 6'b100000;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         checks++; if (upd_o[2:1] !== 2'b00 || gray_o[17:6] !== '0 || bin_o[17:6] !== '0) begin errors++; $display("FAIL mc_idle e%0d: got upd %b gray %h bin %h expected 00/000/000", k, upd_o[2:1], gray_o[17:6], bin_o[17:6]); end
         if (k == 3) begin
            checks++; if (upd_o !== 4'b1001 || bin_o[5:0] !== 6'd1 || bin_o[23:18] !== 6'd63) begin errors++; $display("FAIL mc_upd: got upd %b b0 %0d b3 %0d expected 1001/1/63", upd_o, bin_o[5:0], bin_o[23:18]); end
         end
      end
   endtask

   task automatic test_sync3();
      g3_i = 6'b000001;
      tick(2);
      checks++; if (g3_o !== 6'd0) begin errors++; $display("FAIL s3_e2: got gray %b expected 000000", g3_o); end
      tick(1);
      checks++; if (g3_o !== 6'b000001 || b3_o !== 6'd0 || u3_o !== 1'b0) begin errors++; $display("FAIL s3_e3: got gray %b bin %0d upd %b expected 000001/0/0", g3_o, b3_o, u3_o); end
      tick(1);
      checks++; if (b3_o !== 6'd1 || u3_o !== 1'b1) begin errors++; $display("FAIL s3_e4: got bin %0d upd %b expected 1/1", b3_o, u3_o); end
      tick(1);
      checks++; if (u3_o !== 1'b0 || e3_o !== 1'b0) begin errors++; $display("FAIL s3_e5: got upd %b err %b expected 0/0", u3_o, e3_o); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_wrap();
      test_back_to_back();
      test_error();
      test_multi_channel();
      test_sync3();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
